seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the stopwatch display driver: monitors the multiplexed, active-low seg/an bus and reconstructs the four displayed digits as BCD.
- Used as an on-chip self-check and as a bench monitor.
- Filters anode-switch transients and decodes 7-segment glyphs back to digit codes.
- Emits one frame per completed 4-digit scan and flags malformed patterns or a stalled scan.

Parameters:
- SETTLE_CYCLES, 16: consecutive cycles an/seg must be unchanged before a digit is sampled.
- TIMEOUT_CYCLES, 1000000: cycles without any digit capture before stale asserts.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seg  in  7  segment bus, active-low; seg[0]=a … seg[6]=g.
- an  in  4  anode bus, active-low; an[0] is the rightmost digit (seconds ones), an[3] the leftmost (minutes tens).
- digits  out  16  last complete frame; digits[4k+3:4k] is the digit under an[k].
- frame_valid  out  1  one-cycle pulse; digits updated this same cycle.
- pattern_err  out  1  set if any digit in the frame just delivered held an undecodable glyph.
- ghost_err  out  1  one-cycle pulse when a settled an has more than one bit low.
- stale  out  1  level; no capture for TIMEOUT_CYCLES.

Behaviour:
- Reset (async assert, sync release): every output is 0 and all internal state is cleared: counters, captured mask, held digits.
- Input registering: seg and an are registered once. All logic below uses the registered values (1 cycle of input latency).
- Settle counter:
  - Reset to 0 on any change of {an, seg} versus the previous cycle; otherwise increments, saturating at SETTLE_CYCLES.
  - "Settled" means the counter equals SETTLE_CYCLES-1 on the current cycle.
  - Sampling happens exactly once per settled dwell. No resample occurs until {an, seg} changes.
- States: IDLE (no capture yet in this frame), COLLECT (mask non-zero), DELIVER (single cycle). On reaching DELIVER:
  - frame_valid=1, digits and pattern_err load from the held registers.
  - mask clears and the block returns to IDLE.
- At a settled sample:
  - an==4'b1111 (blank): ignored, no capture.
  - Exactly one bit k low: decode seg, store into held digit k, set mask[k].
  - More than one bit low: pulse ghost_err, no capture, mask unchanged.
- Glyph decode, with seg given as g..a, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - All-ones (blank) decodes to 4'hF and is not an error.
  - Any other pattern decodes to 4'hE and sets a per-frame error bit.
- Re-capture of a digit already in mask before the frame completes: newest value overwrites; mask is unchanged.
- Frame completion:
  - When the capture sets the last missing mask bit (mask becomes 4'hF), DELIVER occurs on the next cycle.
  - The error bit is cleared with the mask.
  - Order of digit arrival is irrelevant.
- Stale timer:
  - Counts every cycle and resets to 0 on any capture.
  - stale=1 while count ≥ TIMEOUT_CYCLES; count saturates.
  - stale clears on the cycle after the next capture.
  - Held digits and mask are kept during stale.
- Reset mid-frame: partial mask discarded; no frame_valid is produced for it.
- Counter widths are $clog2 of the respective parameter +1; no wrap.

Test Plan:
- Reset hold, then an=1111, seg=1111111 for 100 cycles → all outputs 0, no frame_valid, stale=0.
- Scan an=1110/1101/1011/0111 with glyphs 9,5,2,1, each held 40 cycles → one frame_valid pulse after the fourth dwell settles; digits=16'h1259, pattern_err=0.
- Glitch: an toggles every 5 cycles (below SETTLE_CYCLES) for 200 cycles, then a clean scan of 0,0,0,0 → only the clean scan produces frame_valid, digits=16'h0000.
- Invalid glyph seg=1010101 on an[2] within an otherwise valid scan of 3,4,x,7 → digits=16'h7E43, pattern_err=1. The next clean frame clears pattern_err to 0.
- an=1100 held 40 cycles → single ghost_err pulse, mask unchanged. A subsequent full scan still produces exactly one frame.
- Freeze an=1110 for TIMEOUT_CYCLES+10 (parameter overridden to 200) → stale=1. Resume scanning → stale=0 after the first capture; a frame follows. Repeat with rst_n asserted after 2 captures → no frame, outputs 0.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// Multiplexed 7-segment scan bus as seen by the decoder, plus the reconstructed frame outputs.
// The master drives seg/an; the slave (decoder) returns digits and status.
interface seg_scan_decoder_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic        frame_valid;
    logic        pattern_err;
    logic        ghost_err;
    logic        stale;

    modport master (
        output seg, an,
        input  digits, frame_valid, pattern_err, ghost_err, stale
    );

    modport slave (
        input  seg, an,
        output digits, frame_valid, pattern_err, ghost_err, stale
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Purpose: rebuild the four BCD digits shown on an active-low multiplexed seg/an bus.
// Latency: 1 input register cycle + SETTLE_CYCLES dwell per digit; frame pulses the cycle after the last capture.
// Backpressure: none; a passive monitor that never stalls the bus it observes.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_decoder_if.slave bus
);

    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DELIVER} state_t;

    state_t        state, state_next;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] stale_cnt;
    logic [3:0]    mask;
    logic          err;
    logic [15:0]   held;
    logic [15:0]   digits_r;
    logic          perr_r;
    logic          ghost_r;

    logic          changed, settled;
    logic [3:0]    low;
    logic          single_low, multi_low;
    logic          capture, ghost_hit;
    logic [3:0]    dec_val;
    logic          dec_bad;
    logic [3:0]    mask_next;
    logic          err_next;

    // Returns {bad, value}; blank is a legal glyph that reads back as F.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b0, 4'h0};
            7'b1111001: r = {1'b0, 4'h1};
            7'b0100100: r = {1'b0, 4'h2};
            7'b0110000: r = {1'b0, 4'h3};
            7'b0011001: r = {1'b0, 4'h4};
            7'b0010010: r = {1'b0, 4'h5};
            7'b0000010: r = {1'b0, 4'h6};
            7'b1111000: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0010000: r = {1'b0, 4'h9};
            7'b1111111: r = {1'b0, 4'hF};
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    always_comb begin
        changed    = ({an_q, seg_q} != {an_d, seg_d});
        // The !changed term keeps a value that differs from last cycle from being sampled on a stale count.
        settled    = (settle_cnt == SW'(SETTLE_CYCLES - 1)) && !changed;
        low        = ~an_q;
        single_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
        multi_low  = (low != 4'd0) && !single_low;
        capture    = settled && single_low;
        ghost_hit  = settled && multi_low;
        {dec_bad, dec_val} = decode(seg_q);
        // DELIVER empties the frame, so a capture there starts the next one from scratch.
        mask_next  = ((state == DELIVER) ? 4'd0 : mask) | (capture ? low : 4'd0);
        err_next   = ((state == DELIVER) ? 1'b0 : err) | (capture & dec_bad);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = (mask_next == 4'hF) ? DELIVER : COLLECT;
            COLLECT: if (mask_next == 4'hF) state_next = DELIVER;
            DELIVER: begin
                if (mask_next == 4'hF)      state_next = DELIVER;
                else if (mask_next != 4'd0) state_next = COLLECT;
                else                        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: on the DELIVER cycle the held digits go straight out.
    always_comb begin
        bus.frame_valid = (state == DELIVER);
        bus.digits      = (state == DELIVER) ? held : digits_r;
        bus.pattern_err = (state == DELIVER) ? err  : perr_r;
        bus.ghost_err   = ghost_r;
        bus.stale       = (stale_cnt >= TW'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            an_q       <= '0;
            seg_d      <= '0;
            an_d       <= '0;
            settle_cnt <= '0;
            stale_cnt  <= '0;
            mask       <= '0;
            err        <= 1'b0;
            held       <= '0;
            digits_r   <= '0;
            perr_r     <= 1'b0;
            ghost_r    <= 1'b0;
        end else begin
            seg_q <= bus.seg;
            an_q  <= bus.an;
            seg_d <= seg_q;
            an_d  <= an_q;

            if (changed)                               settle_cnt <= '0;
            else if (settle_cnt < SW'(SETTLE_CYCLES))  settle_cnt <= settle_cnt + 1'b1;

            if (capture)                               stale_cnt <= '0;
            else if (stale_cnt < TW'(TIMEOUT_CYCLES))  stale_cnt <= stale_cnt + 1'b1;

            mask    <= mask_next;
            err     <= err_next;
            ghost_r <= ghost_hit;

            for (int k = 0; k < 4; k++) begin
                if (capture && low[k]) held[4*k +: 4] <= dec_val;
            end

            if (state == DELIVER) begin
                digits_r <= held;
                perr_r   <= err;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full scans plus hand-written glitch, ghost, stale and reset sequences.
module tb_seg_scan_decoder;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                           G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                           G9 = 7'b0010000, GB = 7'b1111111, GX = 7'b1010101;
    localparam int DWELL = 40;

    typedef struct {
        logic [6:0]  g0, g1, g2, g3;
        logic [15:0] exp_digits;
        logic        exp_perr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   fv_cnt = 0;
    int   ghost_cnt = 0;
    logic [15:0] last_digits = '0;
    logic        last_perr = 1'b0;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(200)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            fv_cnt++;
            last_digits = bus.digits;
            last_perr   = bus.pattern_err;
        end
        if (bus.ghost_err === 1'b1) ghost_cnt++;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        @(negedge clk);
        bus.an  = a;
        bus.seg = s;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2, input logic [6:0] g3);
        hold(4'b1110, g0, DWELL);
        hold(4'b1101, g1, DWELL);
        hold(4'b1011, g2, DWELL);
        hold(4'b0111, g3, DWELL);
    endtask

    vec_t vecs[5];

    initial begin
        int fv0, gh0;
        vecs[0] = '{G0, G0, G0, G0, 16'h0000, 1'b0};
        vecs[1] = '{G9, G5, G2, G1, 16'h1259, 1'b0};
        vecs[2] = '{G3, G4, GX, G7, 16'h7E43, 1'b1};
        vecs[3] = '{G8, G6, GB, G0, 16'h0F68, 1'b0};
        vecs[4] = '{G9, G5, G2, G1, 16'h1259, 1'b0};

        bus.an  = 4'b1111;
        bus.seg = GB;
        repeat (3) @(negedge clk);
        check("rst_digits", bus.digits, 16'h0000);
        check("rst_fv",     {15'd0, bus.frame_valid}, 16'd0);
        check("rst_perr",   {15'd0, bus.pattern_err}, 16'd0);
        check("rst_ghost",  {15'd0, bus.ghost_err}, 16'd0);
        check("rst_stale",  {15'd0, bus.stale}, 16'd0);

        rst_n = 1'b1;
        hold(4'b1111, GB, 100);
        check("idle_fv_cnt", 16'(fv_cnt), 16'd0);
        check("idle_stale",  {15'd0, bus.stale}, 16'd0);
        check("idle_digits", bus.digits, 16'h0000);

        // Anode flips faster than the settle window: nothing may be captured.
        fv0 = fv_cnt;
        for (int i = 0; i < 40; i++) hold((i % 2 == 0) ? 4'b1110 : 4'b1101, G9, 5);
        check("glitch_fv_cnt", 16'(fv_cnt - fv0), 16'd0);
        check("glitch_ghost",  16'(ghost_cnt), 16'd0);

        for (int v = 0; v < 5; v++) begin
            fv0 = fv_cnt;
            scan4(vecs[v].g0, vecs[v].g1, vecs[v].g2, vecs[v].g3);
            check($sformatf("vec%0d_fv_cnt", v), 16'(fv_cnt - fv0), 16'd1);
            check($sformatf("vec%0d_digits", v), last_digits, vecs[v].exp_digits);
            check($sformatf("vec%0d_perr", v),   {15'd0, last_perr}, {15'd0, vecs[v].exp_perr});
        end
        check("held_digits_after_frame", bus.digits, 16'h1259);

        // Ghost in the middle of a frame must not disturb the partial mask.
        fv0 = fv_cnt;
        gh0 = ghost_cnt;
        hold(4'b1110, G2, DWELL);
        hold(4'b1101, G7, DWELL);
        hold(4'b1100, G8, DWELL);
        check("ghost_pulses", 16'(ghost_cnt - gh0), 16'd1);
        check("ghost_no_frame", 16'(fv_cnt - fv0), 16'd0);
        hold(4'b1011, G0, DWELL);
        hold(4'b0111, G6, DWELL);
        check("ghost_fv_cnt", 16'(fv_cnt - fv0), 16'd1);
        check("ghost_digits", last_digits, 16'h6072);

        // Frozen scan: one capture, then no more until stale.
        fv0 = fv_cnt;
        hold(4'b1110, G1, 240);
        check("stale_set", {15'd0, bus.stale}, 16'd1);
        check("stale_digits_kept", bus.digits, 16'h6072);
        hold(4'b1101, G2, DWELL);
        check("stale_clear", {15'd0, bus.stale}, 16'd0);
        hold(4'b1011, G3, DWELL);
        hold(4'b0111, G4, DWELL);
        check("stale_fv_cnt", 16'(fv_cnt - fv0), 16'd1);
        check("stale_digits", last_digits, 16'h4321);

        // Reset after two captures drops the partial frame.
        fv0 = fv_cnt;
        hold(4'b1110, G5, DWELL);
        hold(4'b1101, G6, DWELL);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_digits", bus.digits, 16'h0000);
        check("midrst_stale",  {15'd0, bus.stale}, 16'd0);
        check("midrst_perr",   {15'd0, bus.pattern_err}, 16'd0);
        rst_n = 1'b1;
        hold(4'b1011, G7, DWELL);
        hold(4'b0111, G8, DWELL);
        check("midrst_no_frame", 16'(fv_cnt - fv0), 16'd0);
        check("midrst_digits_after", bus.digits, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
